// File: rtl/shufflenet_acc_requant.sv
// shufflenet_acc_requant: accumulates product groups and round-shift requantizes to a saturated activation (optional out_ovf via SHUFFLENET_ACC_OVF_EN)
module shufflenet_acc_requant #(
  parameter int PROD_W    = 22,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 8,
  parameter int SHIFT_W   = 5,
  parameter int MAX_TERMS = 512
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [PROD_W-1:0]  in_prod,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SHIFT_W-1:0] cfg_shift,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready
`ifdef SHUFFLENET_ACC_OVF_EN
  ,
  output logic               out_ovf
`endif
);
  localparam int CW = $clog2(MAX_TERMS) + 1;
  localparam logic [ACC_W:0] ONE = 1;
  typedef enum logic [1:0] {ACC, RQ, HOLD} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d;
  logic beat, first, close, xfer, clamp;
  logic [ACC_W:0] ext, sum, rnd, r;
  assign beat  = in_valid && state_q == ACC;
  assign xfer  = out_valid_q && out_ready;
  assign first = cnt_q == '0;
  assign close = in_last || (cnt_q + CW'(1) == CW'(MAX_TERMS));
  assign ext   = {{(ACC_W-PROD_W+1){1'b0}}, in_prod};
  assign sum   = {1'b0, acc_q} + ext;
  // rounding add is one bit wider than the accumulator so it can never wrap
  assign rnd   = shift_q == '0 ? '0 : ONE << (shift_q - SHIFT_W'(1));
  assign r     = ({1'b0, acc_q} + rnd) >> shift_q;
  assign clamp = |r[ACC_W:OUT_W];
  assign in_ready  = state_q == ACC;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  // next-state: accumulate beats, requantize for one cycle, hold until taken
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (beat) begin
      acc_d   = first ? ext[ACC_W-1:0] : (sum[ACC_W] ? '1 : sum[ACC_W-1:0]);
      shift_d = first ? cfg_shift : shift_q;
      cnt_d   = cnt_q + CW'(1);
      state_d = close ? RQ : ACC;
    end else if (state_q == RQ) begin
      out_data_d  = clamp ? '1 : r[OUT_W-1:0];
      out_valid_d = 1'b1;
      state_d     = HOLD;
    end else if (state_q == HOLD && xfer) begin
      out_valid_d = 1'b0;
      acc_d       = '0;
      cnt_d       = '0;
      state_d     = ACC;
    end
  end
  // state registers, cleared immediately on reset
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end
`ifdef SHUFFLENET_ACC_OVF_EN
  logic sat_q, sat_d, ovf_q, ovf_d;
  assign sat_d   = beat ? (!first && (sat_q || sum[ACC_W])) : (xfer ? 1'b0 : sat_q);
  assign ovf_d   = state_q == RQ ? (sat_q || clamp) : ovf_q;
  assign out_ovf = ovf_q;
  // sticky saturation flag for the open group, latched alongside the result
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
      ovf_q <= ovf_d;
    end
  end
`endif
endmodule

// File: tb/tb_shufflenet_acc_requant.sv
// tb_shufflenet_acc_requant: directed checks of accumulate, requantize, backpressure, saturation, term limit and async reset
module tb_shufflenet_acc_requant;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic [21:0] in_prod = '0;
  logic in_last = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [4:0] cfg_shift = '0;
  logic [7:0] d0, d1, d2;
  logic v0, v1, v2, r0, r1, r2;
  int checks = 0, failures = 0;
`ifdef SHUFFLENET_ACC_OVF_EN
  logic f0, f1, f2;
`endif
  always #5 ap_clk = ~ap_clk;
  shufflenet_acc_requant u0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_prod(in_prod), .in_last(in_last), .in_valid(in_valid),
    .in_ready(r0), .cfg_shift(cfg_shift), .out_data(d0), .out_valid(v0), .out_ready(out_ready)
`ifdef SHUFFLENET_ACC_OVF_EN
    , .out_ovf(f0)
`endif
  );
  shufflenet_acc_requant #(.ACC_W(24)) u1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_prod(in_prod), .in_last(in_last), .in_valid(in_valid),
    .in_ready(r1), .cfg_shift(cfg_shift), .out_data(d1), .out_valid(v1), .out_ready(out_ready)
`ifdef SHUFFLENET_ACC_OVF_EN
    , .out_ovf(f1)
`endif
  );
  shufflenet_acc_requant #(.MAX_TERMS(4)) u2 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_prod(in_prod), .in_last(in_last), .in_valid(in_valid),
    .in_ready(r2), .cfg_shift(cfg_shift), .out_data(d2), .out_valid(v2), .out_ready(out_ready)
`ifdef SHUFFLENET_ACC_OVF_EN
    , .out_ovf(f2)
`endif
  );
  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask
  task automatic drive(input logic [21:0] p, input logic l);
    in_valid = 1'b1;
    in_prod = p;
    in_last = l;
    tick();
  endtask
  task automatic idle;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic do_reset;
    idle();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
  endtask
  task automatic test_reset;
    #1;
    checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", v0); end
    checks++; if (d0 !== 8'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", d0); end
`ifdef SHUFFLENET_ACC_OVF_EN
    checks++; if (f0 !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", f0); end
`endif
    tick();
    ap_rst = 1'b0;
    tick();
    checks++; if (r0 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", r0); end
  endtask
  task automatic test_basic;
    do_reset();
    out_ready = 1'b1;
    cfg_shift = 5'd2;
    drive(22'd100, 1'b0);
    cfg_shift = 5'd7;
    drive(22'd60, 1'b1);
    idle();
    checks++; if (r0 !== 1'b0 || v0 !== 1'b0) begin failures++; $display("FAIL basic_rq got ready=%b valid=%b exp ready=0 valid=0", r0, v0); end
    tick();
    checks++; if (v0 !== 1'b1 || d0 !== 8'd40) begin failures++; $display("FAIL basic_result got valid=%b data=%0d exp valid=1 data=40", v0, d0); end
    checks++; if (r0 !== 1'b0) begin failures++; $display("FAIL basic_hold_ready got=%b exp=0", r0); end
    tick();
    checks++; if (v0 !== 1'b0 || r0 !== 1'b1) begin failures++; $display("FAIL basic_xfer got valid=%b ready=%b exp valid=0 ready=1", v0, r0); end
  endtask
  task automatic test_shift_cases;
    do_reset();
    out_ready = 1'b1;
    cfg_shift = 5'd0;
    drive(22'd200, 1'b1);
    idle();
    tick();
    checks++; if (v0 !== 1'b1 || d0 !== 8'd200) begin failures++; $display("FAIL shift0 got valid=%b data=%0d exp valid=1 data=200", v0, d0); end
`ifdef SHUFFLENET_ACC_OVF_EN
    checks++; if (f0 !== 1'b0) begin failures++; $display("FAIL shift0_ovf got=%b exp=0", f0); end
`endif
    tick();
    cfg_shift = 5'd4;
    drive(22'd1000, 1'b0);
    drive(22'd2000, 1'b0);
    drive(22'd3000, 1'b1);
    idle();
    tick();
    checks++; if (v0 !== 1'b1 || d0 !== 8'd255) begin failures++; $display("FAIL clamp got valid=%b data=%0d exp valid=1 data=255", v0, d0); end
`ifdef SHUFFLENET_ACC_OVF_EN
    checks++; if (f0 !== 1'b1) begin failures++; $display("FAIL clamp_ovf got=%b exp=1", f0); end
`endif
    tick();
  endtask
  task automatic test_backpressure;
    do_reset();
    out_ready = 1'b0;
    cfg_shift = 5'd0;
    drive(22'd5, 1'b1);
    in_prod = 22'd9;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (v0 !== 1'b1 || d0 !== 8'd5 || r0 !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got valid=%b data=%0d ready=%b exp valid=1 data=5 ready=0", i, v0, d0, r0); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++; if (v0 !== 1'b0 || r0 !== 1'b1) begin failures++; $display("FAIL bp_xfer got valid=%b ready=%b exp valid=0 ready=1", v0, r0); end
    tick();
    idle();
    checks++; if (r0 !== 1'b0) begin failures++; $display("FAIL bp_next_taken got ready=%b exp=0", r0); end
    tick();
    checks++; if (v0 !== 1'b1 || d0 !== 8'd9) begin failures++; $display("FAIL bp_next_result got valid=%b data=%0d exp valid=1 data=9", v0, d0); end
    tick();
  endtask
  task automatic test_acc_saturate;
    do_reset();
    out_ready = 1'b1;
    cfg_shift = 5'd16;
    for (int i = 0; i < 5; i++) drive(22'd4194303, i == 4);
    idle();
    tick();
    checks++; if (v1 !== 1'b1 || d1 !== 8'd255) begin failures++; $display("FAIL sat_result got valid=%b data=%0d exp valid=1 data=255", v1, d1); end
`ifdef SHUFFLENET_ACC_OVF_EN
    checks++; if (f1 !== 1'b1) begin failures++; $display("FAIL sat_ovf got=%b exp=1", f1); end
`endif
    tick();
  endtask
  task automatic test_max_terms;
    do_reset();
    out_ready = 1'b1;
    cfg_shift = 5'd0;
    for (int i = 0; i < 4; i++) drive(22'd1, 1'b0);
    checks++; if (r2 !== 1'b0) begin failures++; $display("FAIL max_close got ready=%b exp=0", r2); end
    tick();
    checks++; if (v2 !== 1'b1 || d2 !== 8'd4) begin failures++; $display("FAIL max_result got valid=%b data=%0d exp valid=1 data=4", v2, d2); end
    tick();
    drive(22'd1, 1'b0);
    drive(22'd1, 1'b0);
    idle();
    for (int i = 0; i < 3; i++) tick();
    checks++; if (v2 !== 1'b0 || r2 !== 1'b1) begin failures++; $display("FAIL max_open got valid=%b ready=%b exp valid=0 ready=1", v2, r2); end
  endtask
  task automatic test_async_reset;
    do_reset();
    out_ready = 1'b0;
    cfg_shift = 5'd0;
    drive(22'd5, 1'b1);
    idle();
    tick();
    checks++; if (v0 !== 1'b1) begin failures++; $display("FAIL ar_pending got valid=%b exp=1", v0); end
    #2 ap_rst = 1'b1;
    #1;
    checks++; if (v0 !== 1'b0 || d0 !== 8'd0) begin failures++; $display("FAIL ar_hold_abort got valid=%b data=%0d exp valid=0 data=0", v0, d0); end
    #1 ap_rst = 1'b0;
    tick();
    out_ready = 1'b1;
    drive(22'd30, 1'b0);
    drive(22'd40, 1'b0);
    idle();
    #2 ap_rst = 1'b1;
    #1;
    checks++; if (v0 !== 1'b0 || r0 !== 1'b1) begin failures++; $display("FAIL ar_mid_group got valid=%b ready=%b exp valid=0 ready=1", v0, r0); end
    #1 ap_rst = 1'b0;
    tick();
    drive(22'd7, 1'b1);
    idle();
    tick();
    checks++; if (v0 !== 1'b1 || d0 !== 8'd7) begin failures++; $display("FAIL ar_fresh got valid=%b data=%0d exp valid=1 data=7", v0, d0); end
    tick();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_shift_cases();
    test_backpressure();
    test_acc_saturate();
    test_max_terms();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
